// File: rtl/eth_rmii_tx.sv
// eth_rmii_tx -- RMII transmit framer.
//
// Takes one frame at a time as a byte stream (destination MAC through payload),
// then drives it onto the RMII pins as dibits at the 50 MHz reference clock.
// The frame goes out as preamble + SFD, the data bytes, an optional zero pad,
// the CRC-32 FCS, and then the inter-frame gap.
//
// Optional feature (compile-time macro):
//   TX_PAD_EN  When defined, frames shorter than MIN_LEN bytes are extended
//              with 0x00 bytes up to MIN_LEN. The pad bytes are covered by the
//              FCS. When undefined, short frames are sent exactly as given.
//
// Parameters:
//   MAX_LEN    largest frame accepted, FCS excluded. One more byte aborts the frame.
//   MIN_LEN    pad target, FCS excluded. Only takes effect with TX_PAD_EN.
//   IFG_BYTES  inter-frame gap in byte times. One byte time is 4 sys_clk.
//
// Ports:
//   sys_clk    50 MHz RMII reference clock. All logic runs on its rising edge.
//   sys_rstn   asynchronous active-low reset
//   in_data    frame byte
//   in_valid   in_data is valid
//   in_last    in_data is the final byte of the frame
//   in_ready   one-cycle accept strobe. The byte is taken when in_valid & in_ready.
//   eth_txen   RMII TX_EN
//   eth_txd    RMII TXD. Bit 0 carries the earlier bit.
//   busy       high from frame start through the end of the IFG
//   tx_done    pulse during the cycle that drives the last FCS dibit
//   tx_err     pulse on an underrun or an overlength abort

module eth_rmii_tx #(
    parameter int unsigned MAX_LEN   = 1514,
    parameter int unsigned MIN_LEN   = 60,
    parameter int unsigned IFG_BYTES = 12
) (
    input  logic       sys_clk,
    input  logic       sys_rstn,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       in_last,
    output logic       in_ready,
    output logic       eth_txen,
    output logic [1:0] eth_txd,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_err
);

    localparam int unsigned IFG_CYC  = IFG_BYTES * 4;
    localparam logic [15:0] IFG_LAST = 16'(IFG_CYC - 1);
    localparam logic [10:0] MAX_CNT  = 11'(MAX_LEN);

    if (MIN_LEN > MAX_LEN || MAX_LEN > 2047 || IFG_BYTES == 0 || IFG_CYC > 65536) begin : g_param_check
        $error("eth_rmii_tx: inconsistent MAX_LEN/MIN_LEN/IFG_BYTES");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_DATA,
        S_PAD,
        S_FCS,
        S_IFG,
        S_DRAIN
    } state_t;

    state_t      state;
    logic [4:0]  cnt;        // dibit index in PRE (0..31), DATA/PAD (0..3), FCS (0..15)
    logic [15:0] ifg_cnt;
    logic [10:0] byte_cnt;
    logic [31:0] crc;
    logic [7:2]  data_q;     // dibit [1:0] goes out straight from in_data, so it is not stored
    logic        last_q;

    logic        take_slot;
    logic        need_pad;
    logic [1:0]  data_next;
    logic [10:0] byte_next;

    // Reflected CRC-32, one bit at a time, LSB-first.
    function automatic logic [31:0] crc_bit(input logic [31:0] c, input logic b);
        if (c[0] ^ b) begin
            return (c >> 1) ^ 32'hEDB88320;
        end
        return c >> 1;
    endfunction

    function automatic logic [31:0] crc_dibit(input logic [31:0] c, input logic [1:0] d);
        return crc_bit(crc_bit(c, d[0]), d[1]);
    endfunction

    always_comb begin
        // in_ready is only ever raised for a byte slot in PRE/DATA, or held in DRAIN
        take_slot = in_ready && (state != S_DRAIN);

`ifdef TX_PAD_EN
        need_pad = (byte_cnt < 11'(MIN_LEN));
`else
        need_pad = 1'b0;
`endif

        case (cnt[1:0])
            2'd0:    data_next = data_q[3:2];
            2'd1:    data_next = data_q[5:4];
            default: data_next = data_q[7:6];
        endcase

        byte_next = (byte_cnt == 11'h7FF) ? byte_cnt : byte_cnt + 11'd1;
    end

    always_ff @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            state    <= S_IDLE;
            eth_txen <= 1'b0;
            eth_txd  <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            tx_done  <= 1'b0;
            tx_err   <= 1'b0;
            cnt      <= '0;
            ifg_cnt  <= '0;
            byte_cnt <= '0;
            crc      <= '1;
            data_q   <= '0;
            last_q   <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            tx_err  <= 1'b0;

            if (take_slot) begin
                // Byte slot: the last PRE cycle or the 4th dibit of a non-final byte
                in_ready <= 1'b0;
                if (!in_valid) begin
                    eth_txen <= 1'b0;
                    eth_txd  <= '0;
                    tx_err   <= 1'b1;
                    ifg_cnt  <= '0;
                    state    <= S_IFG;
                end else if (byte_cnt == MAX_CNT) begin
                    eth_txen <= 1'b0;
                    eth_txd  <= '0;
                    tx_err   <= 1'b1;
                    if (in_last) begin
                        ifg_cnt <= '0;
                        state   <= S_IFG;
                    end else begin
                        in_ready <= 1'b1;
                        state    <= S_DRAIN;
                    end
                end else begin
                    data_q   <= in_data[7:2];
                    last_q   <= in_last;
                    byte_cnt <= byte_next;
                    eth_txd  <= in_data[1:0];
                    crc      <= crc_dibit(crc, in_data[1:0]);
                    cnt      <= '0;
                    state    <= S_DATA;
                end
            end else begin
                case (state)
                    S_IDLE: begin
                        if (in_valid) begin
                            eth_txen <= 1'b1;
                            eth_txd  <= 2'b01;
                            busy     <= 1'b1;
                            cnt      <= '0;
                            byte_cnt <= '0;
                            crc      <= '1;
                            state    <= S_PRE;
                        end
                    end

                    S_PRE: begin
                        cnt <= cnt + 5'd1;
                        if (cnt == 5'd30) begin
                            eth_txd  <= 2'b11;
                            in_ready <= 1'b1;
                        end else begin
                            eth_txd <= 2'b01;
                        end
                    end

                    S_DATA: begin
                        if (cnt != 5'd3) begin
                            eth_txd  <= data_next;
                            crc      <= crc_dibit(crc, data_next);
                            cnt      <= cnt + 5'd1;
                            in_ready <= (cnt == 5'd2) && !last_q;
                        end else if (need_pad) begin
                            eth_txd  <= 2'b00;
                            crc      <= crc_dibit(crc, 2'b00);
                            byte_cnt <= byte_next;
                            cnt      <= '0;
                            state    <= S_PAD;
                        end else begin
                            eth_txd <= ~crc[1:0];
                            crc     <= crc >> 2;
                            cnt     <= '0;
                            state   <= S_FCS;
                        end
                    end

`ifdef TX_PAD_EN
                    S_PAD: begin
                        if (cnt != 5'd3) begin
                            eth_txd <= 2'b00;
                            crc     <= crc_dibit(crc, 2'b00);
                            cnt     <= cnt + 5'd1;
                        end else if (need_pad) begin
                            eth_txd  <= 2'b00;
                            crc      <= crc_dibit(crc, 2'b00);
                            byte_cnt <= byte_next;
                            cnt      <= '0;
                        end else begin
                            eth_txd <= ~crc[1:0];
                            crc     <= crc >> 2;
                            cnt     <= '0;
                            state   <= S_FCS;
                        end
                    end
`endif

                    S_FCS: begin
                        // The CRC register is consumed as a shift register while the FCS goes out
                        if (cnt != 5'd15) begin
                            eth_txd <= ~crc[1:0];
                            crc     <= crc >> 2;
                            cnt     <= cnt + 5'd1;
                            tx_done <= (cnt == 5'd14);
                        end else begin
                            eth_txen <= 1'b0;
                            eth_txd  <= '0;
                            ifg_cnt  <= '0;
                            state    <= S_IFG;
                        end
                    end

                    S_IFG: begin
                        // A frame already waiting is picked up in the cycle that ends the gap.
                        // The gap therefore stays exactly IFG_CYC cycles long, with no extra IDLE cycle.
                        if (ifg_cnt == IFG_LAST) begin
                            if (in_valid) begin
                                eth_txen <= 1'b1;
                                eth_txd  <= 2'b01;
                                cnt      <= '0;
                                byte_cnt <= '0;
                                crc      <= '1;
                                state    <= S_PRE;
                            end else begin
                                busy  <= 1'b0;
                                state <= S_IDLE;
                            end
                        end else begin
                            ifg_cnt <= ifg_cnt + 16'd1;
                        end
                    end

                    S_DRAIN: begin
                        if (in_valid && in_last) begin
                            in_ready <= 1'b0;
                            ifg_cnt  <= '0;
                            state    <= S_IFG;
                        end
                    end

                    default: begin
                        eth_txen <= 1'b0;
                        eth_txd  <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b0;
                        state    <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_eth_rmii_tx.sv
// Self-checking bench for eth_rmii_tx.
// The reference model builds each frame at byte level: preamble, SFD, data, pad, then CRC-32 FCS.
// It then splits every byte into LSB-first dibits.

module tb_eth_rmii_tx;

    typedef logic [7:0] bq_t[$];
    typedef bit         bitq_t[$];
    typedef logic [1:0] dq_t[$];

    logic       sys_clk = 1'b0;
    logic       sys_rstn;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_last;
    logic       in_ready;
    logic       eth_txen;
    logic [1:0] eth_txd;
    logic       busy;
    logic       tx_done;
    logic       tx_err;

    int n_pass;
    int n_total;

    eth_rmii_tx #(
        .MAX_LEN   (1514),
        .MIN_LEN   (60),
        .IFG_BYTES (12)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rstn (sys_rstn),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_last  (in_last),
        .in_ready (in_ready),
        .eth_txen (eth_txen),
        .eth_txd  (eth_txd),
        .busy     (busy),
        .tx_done  (tx_done),
        .tx_err   (tx_err)
    );

    always #10 sys_clk = ~sys_clk;

    // ---------------- line monitor (samples on the falling edge) ----------------
    logic [1:0] cap[$];
    int         fstart[$];
    int         flen[$];
    int         gaps[$];
    bit         drop_err[$];
    int         done_cnt = 0;
    int         err_cnt  = 0;
    int         txd_bad  = 0;
    int         done_bad = 0;
    int         low_run  = 0;
    bit         in_tx    = 0;
    bit         had_frame = 0;
    bit         prev_done = 0;

    always @(negedge sys_clk) begin
        if (prev_done && eth_txen) done_bad++;
        if (tx_done && !eth_txen) done_bad++;
        prev_done = tx_done;
        if (tx_done) done_cnt++;
        if (tx_err) err_cnt++;
        if (!eth_txen && eth_txd != 2'b00) txd_bad++;
        if (eth_txen) begin
            if (!in_tx) begin
                in_tx = 1;
                fstart.push_back(cap.size());
                if (had_frame) gaps.push_back(low_run);
            end
            cap.push_back(eth_txd);
        end else begin
            if (in_tx) begin
                in_tx = 0;
                flen.push_back(cap.size() - fstart[$]);
                drop_err.push_back(tx_err);
                had_frame = 1;
                low_run = 0;
            end
            low_run++;
        end
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] crc32(input bq_t b);
        logic [31:0] c = 32'hFFFFFFFF;
        foreach (b[i]) begin
            c = c ^ {24'h0, b[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    function automatic bq_t padded(input bq_t data);
        bq_t fr = data;
`ifdef TX_PAD_EN
        while (fr.size() < 60) fr.push_back(8'h00);
`endif
        return fr;
    endfunction

    function automatic dq_t model(input bq_t data);
        bq_t w;
        dq_t o;
        logic [7:0] b;
        bq_t fr = padded(data);
        logic [31:0] f = crc32(fr);
        for (int i = 0; i < 7; i++) w.push_back(8'h55);
        w.push_back(8'hD5);
        foreach (fr[i]) w.push_back(fr[i]);
        for (int i = 0; i < 4; i++) w.push_back(f[8*i +: 8]);
        foreach (w[i]) begin
            b = w[i];
            for (int j = 0; j < 4; j++) o.push_back(b[2*j +: 2]);
        end
        return o;
    endfunction

    // Number of differing dibits between captured frame f and exp over n dibits (-1 if absent)
    function automatic int frame_diff(input int f, input dq_t exp, input int n);
        int d = 0;
        if (f >= flen.size()) return -1;
        if (flen[f] < n || exp.size() < n) return -1;
        for (int k = 0; k < n; k++) if (cap[fstart[f] + k] !== exp[k]) d++;
        return d;
    endfunction

    function automatic int flen_at(input int f);
        return (f < flen.size()) ? flen[f] : -1;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic drive(input bq_t d, input bitq_t l, input int stop_at, output int taken);
        int guard = 0;
        bit acc;
        taken = 0;
        in_valid = 1'b1;
        in_data  = d[0];
        in_last  = l[0];
        while (taken < stop_at && guard < 20000) begin
            @(negedge sys_clk);
            acc = in_ready;
            @(posedge sys_clk);
            #1;
            guard++;
            if (acc) begin
                taken++;
                if (taken < stop_at) begin
                    in_data = d[taken];
                    in_last = l[taken];
                end
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        int c = 0;
        @(negedge sys_clk);
        while ((busy !== 1'b0 || eth_txen !== 1'b0) && c < 10000) begin
            c++;
            @(negedge sys_clk);
        end
        ok = (c < 10000);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int e0;
        int c;
        @(negedge sys_clk);
        n_total++;
        if ({eth_txen, eth_txd, in_ready, busy, tx_done, tx_err} !== 7'b0) begin
            $display("FAIL reset_outputs: got %b expected 0000000", {eth_txen, eth_txd, in_ready, busy, tx_done, tx_err});
        end else n_pass++;

        #2 sys_rstn = 1'b1;
        repeat (3) @(negedge sys_clk);
        n_total++;
        if ({eth_txen, eth_txd, in_ready, busy, tx_done, tx_err} !== 7'b0) begin
            $display("FAIL idle_after_release: got %b expected 0000000", {eth_txen, eth_txd, in_ready, busy, tx_done, tx_err});
        end else n_pass++;

        // Stream a long frame, then pull reset mid-DATA
        in_data = 8'hA5; in_last = 1'b0; in_valid = 1'b1;
        c = 0;
        while (eth_txen !== 1'b1 && c < 10) begin c++; @(negedge sys_clk); end
        repeat (40) @(negedge sys_clk);
        n_total++;
        if ({eth_txen, busy} !== 2'b11) begin
            $display("FAIL mid_frame_active: got %b expected 11", {eth_txen, busy});
        end else n_pass++;

        e0 = err_cnt;
        #3 sys_rstn = 1'b0;
        #1;
        n_total++;
        if ({eth_txen, eth_txd, busy} !== 4'b0) begin
            $display("FAIL async_reset_drop: got %b expected 0000", {eth_txen, eth_txd, busy});
        end else n_pass++;
        in_valid = 1'b0;
        repeat (3) @(negedge sys_clk);
        #2 sys_rstn = 1'b1;
        repeat (5) @(negedge sys_clk);
        n_total++;
        if (err_cnt !== e0) begin
            $display("FAIL reset_no_err: got %0d err pulses expected 0", err_cnt - e0);
        end else n_pass++;
        n_total++;
        if ({eth_txen, busy, in_ready} !== 3'b0) begin
            $display("FAIL idle_after_reset: got %b expected 000", {eth_txen, busy, in_ready});
        end else n_pass++;
    endtask

    task automatic test_crc_frame();
        string s = "123456789";
        bq_t d; bitq_t l; dq_t exp;
        int f0, d0, e0, taken, fs, fl, exp_len;
        logic [31:0] v, exp_fcs;
        bit ok;
        for (int i = 0; i < 9; i++) begin d.push_back(s[i]); l.push_back(i == 8); end
`ifdef TX_PAD_EN
        exp_len = 288;
        exp_fcs = crc32(padded(d));
`else
        exp_len = 84;
        exp_fcs = 32'hCBF43926;
`endif
        f0 = flen.size(); d0 = done_cnt; e0 = err_cnt;
        drive(d, l, 9, taken);
        wait_idle(ok);
        n_total++;
        if (!(ok && taken == 9)) begin
            $display("FAIL crc_complete: got taken=%0d idle=%0d expected 9/1", taken, ok);
        end else n_pass++;
        n_total++;
        if (flen_at(f0) !== exp_len) begin
            $display("FAIL crc_txen_len: got %0d expected %0d", flen_at(f0), exp_len);
        end else n_pass++;
        exp = model(d);
        n_total++;
        if (frame_diff(f0, exp, exp.size()) !== 0) begin
            $display("FAIL crc_frame_content: got %0d bad dibits expected 0", frame_diff(f0, exp, exp.size()));
        end else n_pass++;
        v = '0;
        fl = flen_at(f0);
        if (fl >= 16) begin
            fs = fstart[f0];
            for (int k = 0; k < 16; k++) v[2*k +: 2] = cap[fs + fl - 16 + k];
        end
        n_total++;
        if (v !== exp_fcs) begin
            $display("FAIL crc_fcs: got %h expected %h", v, exp_fcs);
        end else n_pass++;
        n_total++;
        if (done_cnt - d0 !== 1 || err_cnt !== e0) begin
            $display("FAIL crc_pulses: got done=%0d err=%0d expected 1/0", done_cnt - d0, err_cnt - e0);
        end else n_pass++;
        n_total++;
        if (txd_bad !== 0 || done_bad !== 0) begin
            $display("FAIL txd_idle_and_done_align: got %0d/%0d expected 0/0", txd_bad, done_bad);
        end else n_pass++;
    endtask

    task automatic test_underrun();
        bq_t d; bitq_t l; dq_t exp;
        int f0, d0, e0, taken, c;
        for (int i = 0; i < 20; i++) begin d.push_back(8'($urandom)); l.push_back(i == 19); end
        f0 = flen.size(); d0 = done_cnt; e0 = err_cnt;
        drive(d, l, 5, taken);
        c = 0;
        @(negedge sys_clk);
        while (eth_txen === 1'b1 && c < 50) begin c++; @(negedge sys_clk); end
        n_total++;
        if (tx_err !== 1'b1) begin
            $display("FAIL underrun_err_at_drop: got %b expected 1", tx_err);
        end else n_pass++;
        c = 0;
        while (busy === 1'b1 && c < 200) begin c++; @(negedge sys_clk); end
        n_total++;
        if (c !== 48) begin
            $display("FAIL underrun_ifg_len: got %0d expected 48", c);
        end else n_pass++;
        n_total++;
        if (flen_at(f0) !== 52) begin
            $display("FAIL underrun_txen_len: got %0d expected 52", flen_at(f0));
        end else n_pass++;
        exp = model(d);
        n_total++;
        if (frame_diff(f0, exp, 52) !== 0) begin
            $display("FAIL underrun_content: got %0d bad dibits expected 0", frame_diff(f0, exp, 52));
        end else n_pass++;
        n_total++;
        if (done_cnt - d0 !== 0 || err_cnt - e0 !== 1) begin
            $display("FAIL underrun_pulses: got done=%0d err=%0d expected 0/1", done_cnt - d0, err_cnt - e0);
        end else n_pass++;
    endtask

    task automatic test_overlength();
        bq_t d; bitq_t l; dq_t exp;
        int f0, d0, e0, taken, c;
        for (int i = 0; i < 1520; i++) begin d.push_back(8'($urandom)); l.push_back(i == 1519); end
        f0 = flen.size(); d0 = done_cnt; e0 = err_cnt;
        drive(d, l, 1520, taken);
        n_total++;
        if (taken !== 1520) begin
            $display("FAIL overlen_drained: got %0d bytes taken expected 1520", taken);
        end else n_pass++;
        c = 0;
        @(negedge sys_clk);
        while (busy === 1'b1 && c < 200) begin c++; @(negedge sys_clk); end
        n_total++;
        if (c !== 48) begin
            $display("FAIL overlen_ifg_len: got %0d expected 48", c);
        end else n_pass++;
        n_total++;
        if (flen_at(f0) !== (8 + 1514) * 4) begin
            $display("FAIL overlen_txen_len: got %0d expected %0d", flen_at(f0), (8 + 1514) * 4);
        end else n_pass++;
        exp = model(d);
        n_total++;
        if (frame_diff(f0, exp, (8 + 1514) * 4) !== 0) begin
            $display("FAIL overlen_content: got %0d bad dibits expected 0", frame_diff(f0, exp, (8 + 1514) * 4));
        end else n_pass++;
        n_total++;
        if (f0 >= drop_err.size() || drop_err[f0] !== 1'b1) begin
            $display("FAIL overlen_err_at_drop: got %0d expected 1", (f0 < drop_err.size()) ? drop_err[f0] : 0);
        end else n_pass++;
        n_total++;
        if (done_cnt - d0 !== 0 || err_cnt - e0 !== 1 || in_ready !== 1'b0) begin
            $display("FAIL overlen_pulses: got done=%0d err=%0d rdy=%b expected 0/1/0", done_cnt - d0, err_cnt - e0, in_ready);
        end else n_pass++;
    endtask

    task automatic test_back_to_back();
        bq_t d, a, b; bitq_t l;
        int f0, g0, d0, e0, taken;
        bit ok;
        for (int i = 0; i < 128; i++) begin
            d.push_back(8'($urandom));
            l.push_back(i == 63 || i == 127);
            if (i < 64) a.push_back(d[i]); else b.push_back(d[i]);
        end
        f0 = flen.size(); g0 = gaps.size(); d0 = done_cnt; e0 = err_cnt;
        drive(d, l, 128, taken);
        wait_idle(ok);
        n_total++;
        if (flen_at(f0) !== 304 || flen_at(f0 + 1) !== 304) begin
            $display("FAIL b2b_txen_len: got %0d,%0d expected 304,304", flen_at(f0), flen_at(f0 + 1));
        end else n_pass++;
        n_total++;
        if (frame_diff(f0, model(a), 304) !== 0) begin
            $display("FAIL b2b_frame1: got %0d bad dibits expected 0", frame_diff(f0, model(a), 304));
        end else n_pass++;
        n_total++;
        if (frame_diff(f0 + 1, model(b), 304) !== 0) begin
            $display("FAIL b2b_frame2: got %0d bad dibits expected 0", frame_diff(f0 + 1, model(b), 304));
        end else n_pass++;
        n_total++;
        if (gaps.size() < g0 + 2 || gaps[g0 + 1] !== 48) begin
            $display("FAIL b2b_gap: got %0d expected 48", (gaps.size() >= g0 + 2) ? gaps[g0 + 1] : -1);
        end else n_pass++;
        n_total++;
        if (done_cnt - d0 !== 2 || err_cnt !== e0 || !ok) begin
            $display("FAIL b2b_pulses: got done=%0d err=%0d idle=%0d expected 2/0/1", done_cnt - d0, err_cnt - e0, ok);
        end else n_pass++;
    endtask

    task automatic test_random();
        bq_t d; bitq_t l; dq_t exp;
        int len, f0, d0, taken;
        bit ok;
        d0 = done_cnt;
        for (int k = 0; k < 6; k++) begin
            d.delete(); l.delete();
            len = (k == 0) ? 1 : int'($urandom_range(2, 80));
            for (int i = 0; i < len; i++) begin d.push_back(8'($urandom)); l.push_back(i == len - 1); end
            repeat ($urandom_range(0, 5)) @(negedge sys_clk);
            f0 = flen.size();
            drive(d, l, len, taken);
            wait_idle(ok);
            exp = model(d);
            n_total++;
            if (flen_at(f0) !== exp.size()) begin
                $display("FAIL rand_len[%0d]: got %0d expected %0d", k, flen_at(f0), exp.size());
            end else n_pass++;
            n_total++;
            if (frame_diff(f0, exp, exp.size()) !== 0) begin
                $display("FAIL rand_content[%0d]: got %0d bad dibits expected 0", k, frame_diff(f0, exp, exp.size()));
            end else n_pass++;
        end
        n_total++;
        if (done_cnt - d0 !== 6 || txd_bad !== 0 || done_bad !== 0) begin
            $display("FAIL rand_pulses: got done=%0d txd_bad=%0d done_bad=%0d expected 6/0/0", done_cnt - d0, txd_bad, done_bad);
        end else n_pass++;
    endtask

    initial begin
        sys_rstn = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 8'h00;
        n_pass   = 0;
        n_total  = 0;
        test_reset();
        test_crc_frame();
        test_underrun();
        test_overlength();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #4000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
